// File: rtl/interlaken_pkg.sv
// Shared constants, FSM state type and helpers for the Interlaken 64B/67B receive decoder.
// Also provides the popcount helper used when DECODE_67B_DISP_MON_EN is defined.
package interlaken_pkg;

   localparam int W_PAYLOAD = 64;
   localparam int W_WORD    = 67;

   localparam logic [1:0] HDR_DATA = 2'b01;
   localparam logic [1:0] HDR_CTRL = 2'b10;

   typedef enum logic [1:0] {
      ST_HUNT      = 2'd0,
      ST_SLIP_WAIT = 2'd1,
      ST_LOCKED    = 2'd2
   } lock_state_t;

   function automatic logic hdr_valid(input logic [1:0] hdr);
      return (hdr == HDR_DATA) || (hdr == HDR_CTRL);
   endfunction

`ifdef DECODE_67B_DISP_MON_EN
   function automatic logic [6:0] popcount64(input logic [W_PAYLOAD-1:0] w);
      logic [6:0] n;
      n = '0;
      for (int i = 0; i < W_PAYLOAD; i++) n = n + {6'd0, w[i]};
      return n;
   endfunction
`endif

endpackage

// File: rtl/decode_67b_64b_if.sv
// Word-level bus between the RX gearbox side and the 64B/67B decoder.
// DISP_ERR exists only when DECODE_67B_DISP_MON_EN is defined.
interface decode_67b_64b_if;
   import interlaken_pkg::*;

   logic [W_WORD-1:0]    DATA_IN;
   logic                 DATA_IN_VALID;
   logic                 PASSTHROUGH;
   logic [W_PAYLOAD-1:0] DATA_OUT;
   logic [1:0]           HEADER_OUT;
   logic                 DATA_OUT_VALID;
   logic                 BLOCK_LOCK;
   logic                 SLIP;
   logic                 HEADER_ERR;
   logic [15:0]          ERR_COUNT;
`ifdef DECODE_67B_DISP_MON_EN
   logic                 DISP_ERR;
`endif

   modport master (
      output DATA_IN, DATA_IN_VALID, PASSTHROUGH,
`ifdef DECODE_67B_DISP_MON_EN
      input  DISP_ERR,
`endif
      input  DATA_OUT, HEADER_OUT, DATA_OUT_VALID, BLOCK_LOCK, SLIP, HEADER_ERR, ERR_COUNT
   );

   modport slave (
      input  DATA_IN, DATA_IN_VALID, PASSTHROUGH,
`ifdef DECODE_67B_DISP_MON_EN
      output DISP_ERR,
`endif
      output DATA_OUT, HEADER_OUT, DATA_OUT_VALID, BLOCK_LOCK, SLIP, HEADER_ERR, ERR_COUNT
   );

endinterface

// File: rtl/block_lock_fsm.sv
// Word-boundary block-lock state machine: hunts for a run of good headers, requests
// gearbox slips, maintains lock over fixed windows and counts header errors while locked.
//
// state        | meaning
// ST_HUNT      | counting consecutive valid headers towards lock
// ST_SLIP_WAIT | slip requested; ignoring words while the gearbox settles
// ST_LOCKED    | boundary found; windowed bad-header monitoring
module block_lock_fsm
   import interlaken_pkg::*;
#(
   parameter int LOCK_GOOD_CNT = 64,
   parameter int WIN_LEN       = 64,
   parameter int WIN_BAD_MAX   = 16,
   parameter int SLIP_WAIT     = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        valid,
   input  logic        hdr_ok,
   input  logic        passthrough,
   output logic        lock,
   output logic        slip,
   output logic        in_slip_wait,
   output logic [15:0] err_count
);

   localparam int GW = $clog2(LOCK_GOOD_CNT + 1);
   localparam int SW = $clog2(SLIP_WAIT + 1);
   localparam int WW = $clog2(WIN_LEN + 1);
   localparam int BW = $clog2(WIN_BAD_MAX + 1);

   lock_state_t   state, state_nxt;
   logic [GW-1:0] good_cnt, good_nxt;
   logic [SW-1:0] wait_cnt, wait_nxt;
   logic [WW-1:0] win_cnt, win_nxt;
   logic [BW-1:0] bad_cnt, bad_nxt, bad_inc;
   logic [15:0]   err_nxt;
   logic          lock_nxt, slip_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_HUNT;
         good_cnt  <= '0;
         wait_cnt  <= '0;
         win_cnt   <= '0;
         bad_cnt   <= '0;
         err_count <= '0;
         lock      <= 1'b0;
         slip      <= 1'b0;
      end else begin
         state     <= state_nxt;
         good_cnt  <= good_nxt;
         wait_cnt  <= wait_nxt;
         win_cnt   <= win_nxt;
         bad_cnt   <= bad_nxt;
         err_count <= err_nxt;
         lock      <= lock_nxt;
         slip      <= slip_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      good_nxt  = good_cnt;
      wait_nxt  = wait_cnt;
      win_nxt   = win_cnt;
      bad_nxt   = bad_cnt;
      err_nxt   = err_count;
      lock_nxt  = lock;
      slip_nxt  = 1'b0;
      bad_inc   = bad_cnt + {{(BW-1){1'b0}}, ~hdr_ok};

      if (passthrough) begin
         state_nxt = ST_HUNT;
         good_nxt  = '0;
         wait_nxt  = '0;
         win_nxt   = '0;
         bad_nxt   = '0;
         err_nxt   = '0;
         lock_nxt  = 1'b0;
      end else if (valid) begin
         unique case (state)
            ST_HUNT: begin
               if (hdr_ok) begin
                  if (good_cnt == GW'(LOCK_GOOD_CNT - 1)) begin
                     state_nxt = ST_LOCKED;
                     lock_nxt  = 1'b1;
                     good_nxt  = '0;
                     win_nxt   = '0;
                     bad_nxt   = '0;
                  end else begin
                     good_nxt = good_cnt + 1'b1;
                  end
               end else begin
                  good_nxt  = '0;
                  slip_nxt  = 1'b1;
                  state_nxt = ST_SLIP_WAIT;
                  wait_nxt  = SW'(SLIP_WAIT - 1);
               end
            end
            // Down-counter: the word that sees terminal count is the last one ignored.
            ST_SLIP_WAIT: begin
               if (wait_cnt == '0) begin
                  state_nxt = ST_HUNT;
                  good_nxt  = '0;
               end else begin
                  wait_nxt = wait_cnt - 1'b1;
               end
            end
            ST_LOCKED: begin
               if (!hdr_ok && (err_count != 16'hFFFF)) err_nxt = err_count + 16'd1;
               // Loss of lock is tested before the window wrap so it wins a tie.
               if (bad_inc == BW'(WIN_BAD_MAX)) begin
                  lock_nxt  = 1'b0;
                  slip_nxt  = 1'b1;
                  state_nxt = ST_SLIP_WAIT;
                  wait_nxt  = SW'(SLIP_WAIT - 1);
                  win_nxt   = '0;
                  bad_nxt   = '0;
               end else if (win_cnt == WW'(WIN_LEN - 1)) begin
                  win_nxt = '0;
                  bad_nxt = '0;
               end else begin
                  win_nxt = win_cnt + 1'b1;
                  bad_nxt = bad_inc;
               end
            end
            default: state_nxt = ST_HUNT;
         endcase
      end
   end

   assign in_slip_wait = (state == ST_SLIP_WAIT);

endmodule

// File: rtl/decode_67b_64b.sv
// Interlaken RX 64B/67B decoder: strips framing, undoes payload inversion, runs block lock.
// Optional running-disparity monitor enabled by defining DECODE_67B_DISP_MON_EN.
module decode_67b_64b
   import interlaken_pkg::*;
#(
   parameter int LOCK_GOOD_CNT = 64,
   parameter int WIN_LEN       = 64,
   parameter int WIN_BAD_MAX   = 16,
   parameter int SLIP_WAIT     = 32
`ifdef DECODE_67B_DISP_MON_EN
   ,
   parameter int DISP_LIMIT    = 96
`endif
) (
   input  logic             USER_CLK,
   input  logic             SYSTEM_RESET_N,
   decode_67b_64b_if.slave  dif
);

   logic [1:0]           rst_sync;
   logic                 rst_n;
   logic [1:0]           hdr;
   logic [W_PAYLOAD-1:0] payload, payload_dec;
   logic                 hdr_ok;
   logic                 lock, slip, in_slip_wait;
   logic [15:0]          err_count;
   logic [W_PAYLOAD-1:0] data_q;
   logic [1:0]           hdr_q;
   logic                 valid_q, header_err_q;

   // Reset asserts immediately but releases on a clock edge.
   always_ff @(posedge USER_CLK or negedge SYSTEM_RESET_N) begin
      if (!SYSTEM_RESET_N) rst_sync <= '0;
      else                 rst_sync <= {rst_sync[0], 1'b1};
   end
   assign rst_n = rst_sync[1];

   assign hdr         = dif.DATA_IN[W_PAYLOAD+1:W_PAYLOAD];
   assign payload     = dif.DATA_IN[W_PAYLOAD-1:0];
   assign hdr_ok      = hdr_valid(hdr);
   assign payload_dec = (dif.DATA_IN[W_WORD-1] && !dif.PASSTHROUGH) ? ~payload : payload;

   block_lock_fsm #(
      .LOCK_GOOD_CNT (LOCK_GOOD_CNT),
      .WIN_LEN       (WIN_LEN),
      .WIN_BAD_MAX   (WIN_BAD_MAX),
      .SLIP_WAIT     (SLIP_WAIT)
   ) u_lock (
      .clk          (USER_CLK),
      .rst_n        (rst_n),
      .valid        (dif.DATA_IN_VALID),
      .hdr_ok       (hdr_ok),
      .passthrough  (dif.PASSTHROUGH),
      .lock         (lock),
      .slip         (slip),
      .in_slip_wait (in_slip_wait),
      .err_count    (err_count)
   );

   always_ff @(posedge USER_CLK or negedge rst_n) begin
      if (!rst_n) begin
         data_q       <= '0;
         hdr_q        <= '0;
         valid_q      <= 1'b0;
         header_err_q <= 1'b0;
      end else begin
         valid_q      <= dif.DATA_IN_VALID;
         header_err_q <= dif.DATA_IN_VALID && !hdr_ok && !dif.PASSTHROUGH && !in_slip_wait;
         if (dif.DATA_IN_VALID) begin
            data_q <= payload_dec;
            hdr_q  <= hdr;
         end
      end
   end

   assign dif.DATA_OUT       = data_q;
   assign dif.HEADER_OUT     = hdr_q;
   assign dif.DATA_OUT_VALID = valid_q;
   assign dif.BLOCK_LOCK     = lock;
   assign dif.SLIP           = slip;
   assign dif.HEADER_ERR     = header_err_q;
   assign dif.ERR_COUNT      = err_count;

`ifdef DECODE_67B_DISP_MON_EN
   localparam logic signed [15:0] DLIM = 16'(DISP_LIMIT);

   logic [6:0]          pc;
   logic signed [8:0]   delta;
   logic signed [16:0]  disp_sum;
   logic signed [15:0]  disp_q, disp_nxt;
   logic                disp_err_q, over;

   always_comb begin
      pc       = popcount64(payload);
      delta    = $signed({1'b0, pc, 1'b0}) - 9'sd64;
      disp_sum = {disp_q[15], disp_q} + {{8{delta[8]}}, delta};
      if (disp_sum[16] != disp_sum[15]) disp_nxt = disp_sum[16] ? 16'sh8000 : 16'sh7FFF;
      else                              disp_nxt = disp_sum[15:0];
      over = (disp_nxt > DLIM) || (disp_nxt < -DLIM);
   end

   // lock is low outside LOCKED, so holding the accumulator clear there also clears it on entry.
   always_ff @(posedge USER_CLK or negedge rst_n) begin
      if (!rst_n) begin
         disp_q     <= '0;
         disp_err_q <= 1'b0;
      end else if (dif.PASSTHROUGH || !lock) begin
         disp_q     <= '0;
         disp_err_q <= 1'b0;
      end else if (dif.DATA_IN_VALID) begin
         disp_q <= disp_nxt;
         if (over) disp_err_q <= 1'b1;
      end
   end

   assign dif.DISP_ERR = disp_err_q && lock;
`endif

endmodule

// File: tb/tb_decode_67b_64b.sv
// Self-checking bench for decode_67b_64b: datapath vector table, directed lock sequences,
// and randomized traffic against a queue-based block-lock reference model.
module tb_decode_67b_64b;
   import interlaken_pkg::*;

   logic USER_CLK = 1'b0;
   logic SYSTEM_RESET_N = 1'b0;
   always #5 USER_CLK = ~USER_CLK;

   decode_67b_64b_if dif();
   decode_67b_64b dut (.USER_CLK(USER_CLK), .SYSTEM_RESET_N(SYSTEM_RESET_N), .dif(dif));

   int errors = 0;
   int checks = 0;

   // reference model: mode 0 hunt, 1 waiting after slip, 2 locked
   int          m_mode, m_streak, m_remain, m_err;
   bit          m_win[$];
   logic [63:0] e_data;
   logic [1:0]  e_hdr;
   logic        e_valid, e_lock, e_slip, e_herr;

   typedef struct {
      logic        v;
      logic [66:0] d;
      logic        pt;
      logic [63:0] exp_data;
      logic [1:0]  exp_hdr;
      logic        exp_valid;
   } vec_t;

   task automatic check(string name, logic [63:0] act, logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic void model_reset();
      m_mode = 0; m_streak = 0; m_remain = 0; m_err = 0;
      m_win.delete();
      e_data = '0; e_hdr = '0; e_valid = 0; e_lock = 0; e_slip = 0; e_herr = 0;
   endfunction

   function automatic void model_step(logic v, logic [66:0] d, logic pt);
      bit ok;
      int nbad;
      ok = (d[65:64] == 2'b01) || (d[65:64] == 2'b10);
      e_valid = v; e_slip = 0; e_herr = 0;
      if (v) begin
         e_data = (pt || !d[66]) ? d[63:0] : ~d[63:0];
         e_hdr  = d[65:64];
      end
      if (pt) begin
         m_mode = 0; m_streak = 0; m_remain = 0; m_err = 0; e_lock = 0;
         m_win.delete();
      end else if (v) begin
         if (!ok && m_mode != 1) e_herr = 1;
         case (m_mode)
            0: begin
               if (ok) begin
                  m_streak++;
                  if (m_streak == 64) begin m_mode = 2; e_lock = 1; m_win.delete(); end
               end else begin
                  m_streak = 0; e_slip = 1; m_mode = 1; m_remain = 32;
               end
            end
            1: begin
               m_remain--;
               if (m_remain == 0) begin m_mode = 0; m_streak = 0; end
            end
            default: begin
               if (!ok && m_err < 65535) m_err++;
               m_win.push_back(ok);
               nbad = 0;
               foreach (m_win[i]) if (!m_win[i]) nbad++;
               if (nbad >= 16) begin
                  e_lock = 0; e_slip = 1; m_mode = 1; m_remain = 32; m_win.delete();
               end else if (m_win.size() == 64) begin
                  m_win.delete();
               end
            end
         endcase
      end
   endfunction

   task automatic compare_all(string tag);
      check({tag, ":data_out"},   dif.DATA_OUT, e_data);
      check({tag, ":header_out"}, 64'(dif.HEADER_OUT), 64'(e_hdr));
      check({tag, ":out_valid"},  64'(dif.DATA_OUT_VALID), 64'(e_valid));
      check({tag, ":block_lock"}, 64'(dif.BLOCK_LOCK), 64'(e_lock));
      check({tag, ":slip"},       64'(dif.SLIP), 64'(e_slip));
      check({tag, ":header_err"}, 64'(dif.HEADER_ERR), 64'(e_herr));
      check({tag, ":err_count"},  64'(dif.ERR_COUNT), 64'(m_err));
   endtask

   task automatic word(string tag, logic v, logic [66:0] d, logic pt);
      dif.DATA_IN = d; dif.DATA_IN_VALID = v; dif.PASSTHROUGH = pt;
      model_step(v, d, pt);
      @(posedge USER_CLK);
      @(negedge USER_CLK);
      compare_all(tag);
   endtask

   function automatic logic [66:0] mk(logic inv, logic [1:0] h, logic [63:0] p);
      return {inv, h, p};
   endfunction

   function automatic logic [63:0] rnd64();
      return {$urandom(), $urandom()};
   endfunction

   task automatic good_words(string tag, int n);
      for (int i = 0; i < n; i++) word(tag, 1'b1, mk(1'($urandom_range(0, 1)), 2'b01, rnd64()), 1'b0);
   endtask

   vec_t vt[9];

   initial begin
      vt[0] = '{1'b1, {1'b0, 2'b01, 64'h0123456789ABCDEF}, 1'b0, 64'h0123456789ABCDEF, 2'b01, 1'b1};
      vt[1] = '{1'b1, {1'b1, 2'b01, 64'h0123456789ABCDEF}, 1'b0, 64'hFEDCBA9876543210, 2'b01, 1'b1};
      vt[2] = '{1'b1, {1'b1, 2'b10, 64'hFFFFFFFFFFFFFFFF}, 1'b0, 64'h0000000000000000, 2'b10, 1'b1};
      vt[3] = '{1'b1, {1'b0, 2'b10, 64'h0000000000000000}, 1'b0, 64'h0000000000000000, 2'b10, 1'b1};
      vt[4] = '{1'b0, {1'b1, 2'b01, 64'hAAAAAAAAAAAAAAAA}, 1'b0, 64'h0000000000000000, 2'b10, 1'b0};
      vt[5] = '{1'b1, {1'b1, 2'b01, 64'h5555555555555555}, 1'b0, 64'hAAAAAAAAAAAAAAAA, 2'b01, 1'b1};
      vt[6] = '{1'b0, {1'b0, 2'b10, 64'h0000000000001234}, 1'b0, 64'hAAAAAAAAAAAAAAAA, 2'b01, 1'b0};
      vt[7] = '{1'b1, {1'b0, 2'b01, 64'hDEADBEEFCAFEF00D}, 1'b0, 64'hDEADBEEFCAFEF00D, 2'b01, 1'b1};
      vt[8] = '{1'b1, {1'b1, 2'b10, 64'h0F0F0F0F0F0F0F0F}, 1'b1, 64'h0F0F0F0F0F0F0F0F, 2'b10, 1'b1};

      dif.DATA_IN = '0; dif.DATA_IN_VALID = 1'b0; dif.PASSTHROUGH = 1'b0;
      model_reset();
      repeat (2) @(negedge USER_CLK);
      compare_all("reset");
      SYSTEM_RESET_N = 1'b1;
      for (int i = 0; i < 3; i++) word("idle", 1'b0, '0, 1'b0);

      // datapath vector table
      for (int i = 0; i < 9; i++) begin
         word("vec", vt[i].v, vt[i].d, vt[i].pt);
         check($sformatf("vec%0d_data", i), dif.DATA_OUT, vt[i].exp_data);
         check($sformatf("vec%0d_hdr", i), 64'(dif.HEADER_OUT), 64'(vt[i].exp_hdr));
         check($sformatf("vec%0d_valid", i), 64'(dif.DATA_OUT_VALID), 64'(vt[i].exp_valid));
      end
      word("idle", 1'b0, '0, 1'b0);

      // lock acquisition after exactly 64 good words
      good_words("acq", 63);
      check("lock_after_63", 64'(dif.BLOCK_LOCK), 64'd0);
      word("acq", 1'b1, mk(1'b0, 2'b01, rnd64()), 1'b0);
      check("lock_after_64", 64'(dif.BLOCK_LOCK), 64'd1);

      word("inv", 1'b1, mk(1'b1, 2'b10, 64'h00000000FFFFFFFF), 1'b0);
      check("inv_data", dif.DATA_OUT, 64'hFFFFFFFF00000000);
      check("inv_hdr", 64'(dif.HEADER_OUT), 64'd2);
      check("inv_valid", 64'(dif.DATA_OUT_VALID), 64'd1);

`ifdef DECODE_67B_DISP_MON_EN
      word("disp", 1'b1, mk(1'b0, 2'b01, 64'hFFFFFFFFFFFFFFFF), 1'b0);
      check("disp_err_after_1", 64'(dif.DISP_ERR), 64'd0);
      word("disp", 1'b1, mk(1'b0, 2'b01, 64'hFFFFFFFFFFFFFFFF), 1'b0);
      check("disp_err_after_2", 64'(dif.DISP_ERR), 64'd1);
      word("disp", 1'b1, mk(1'b0, 2'b10, 64'h00000000FFFFFFFF), 1'b0);
      check("disp_err_sticky", 64'(dif.DISP_ERR), 64'd1);
`endif

      // align to a window boundary, then 15 bad per window for 4 windows
      if (m_win.size() != 0) good_words("align", 64 - m_win.size());
      for (int w = 0; w < 4; w++) begin
         for (int i = 0; i < 15; i++) word("win15", 1'b1, mk(1'b0, 2'b00, rnd64()), 1'b0);
         good_words("win15", 49);
      end
      check("lock_held_15x4", 64'(dif.BLOCK_LOCK), 64'd1);
      check("err_count_60", 64'(dif.ERR_COUNT), 64'd60);

      for (int i = 0; i < 15; i++) word("win16", 1'b1, mk(1'b0, 2'b00, rnd64()), 1'b0);
      check("lock_before_16th", 64'(dif.BLOCK_LOCK), 64'd1);
`ifdef DECODE_67B_DISP_MON_EN
      check("disp_err_held", 64'(dif.DISP_ERR), 64'd1);
`endif
      word("win16", 1'b1, mk(1'b0, 2'b00, rnd64()), 1'b0);
      check("lock_lost_16th", 64'(dif.BLOCK_LOCK), 64'd0);
      check("slip_on_loss", 64'(dif.SLIP), 64'd1);
      check("err_count_76", 64'(dif.ERR_COUNT), 64'd76);
`ifdef DECODE_67B_DISP_MON_EN
      check("disp_err_cleared", 64'(dif.DISP_ERR), 64'd0);
`endif

      // slip wait ignores headers, then hunt slips on word 10
      for (int i = 0; i < 32; i++) word("wait", 1'b1, mk(1'b0, (i % 2) ? 2'b11 : 2'b01, rnd64()), 1'b0);
      good_words("hunt", 9);
      word("hunt", 1'b1, mk(1'b0, 2'b11, rnd64()), 1'b0);
      check("hunt_slip", 64'(dif.SLIP), 64'd1);
      check("hunt_herr", 64'(dif.HEADER_ERR), 64'd1);
      word("ign", 1'b1, mk(1'b0, 2'b00, rnd64()), 1'b0);
      check("slip_single", 64'(dif.SLIP), 64'd0);
      check("ign_no_herr", 64'(dif.HEADER_ERR), 64'd0);
      for (int i = 1; i < 32; i++) word("ign", 1'b1, mk(1'b0, 2'b11, rnd64()), 1'b0);
      good_words("relock", 63);
      check("relock_after_63", 64'(dif.BLOCK_LOCK), 64'd0);
      good_words("relock", 1);
      check("relock_after_64", 64'(dif.BLOCK_LOCK), 64'd1);

      // asynchronous reset while locked, no clock edge in between
      #2 SYSTEM_RESET_N = 1'b0;
      #1;
      check("arst_data", dif.DATA_OUT, 64'd0);
      check("arst_valid", 64'(dif.DATA_OUT_VALID), 64'd0);
      check("arst_lock", 64'(dif.BLOCK_LOCK), 64'd0);
      check("arst_hdr", 64'(dif.HEADER_OUT), 64'd0);
      check("arst_err_count", 64'(dif.ERR_COUNT), 64'd0);
      dif.DATA_IN_VALID = 1'b0;
      model_reset();
      @(negedge USER_CLK);
      SYSTEM_RESET_N = 1'b1;
      for (int i = 0; i < 3; i++) word("idle", 1'b0, '0, 1'b0);
      good_words("post_rst", 63);
      check("post_rst_hunt", 64'(dif.BLOCK_LOCK), 64'd0);
      good_words("post_rst", 1);
      check("post_rst_lock", 64'(dif.BLOCK_LOCK), 64'd1);

      // randomized traffic in segments of varying header error rates
      for (int s = 0; s < 20; s++) begin
         int rate;
         case ($urandom_range(0, 2))
            0:       rate = 0;
            1:       rate = 2;
            default: rate = 30;
         endcase
         for (int i = 0; i < 200; i++) begin
            logic [1:0] h;
            logic       v, pt;
            if ($urandom_range(0, 99) < rate) h = $urandom_range(0, 1) ? 2'b11 : 2'b00;
            else                              h = $urandom_range(0, 1) ? 2'b10 : 2'b01;
            v  = ($urandom_range(0, 9) < 8);
            pt = ($urandom_range(0, 299) == 0);
            word("rand", v, mk(1'($urandom_range(0, 1)), h, rnd64()), pt);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
